// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM encoding and
// byte-enable to bit-mask expansion.
package rv_mem_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned NumLanes = DataW / 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StRmwRd  = 2'd2
  } mem_state_e;

  // Each enable bit covers one full byte lane of the word.
  function automatic logic [DataW-1:0] be_to_mask(input logic [NumLanes-1:0] be);
    logic [DataW-1:0] mask;
    mask = '0;
    for (int i = 0; i < NumLanes; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: enabled lanes come from the new word, others keep
// the old word.
module byte_merge
  import rv_mem_pkg::*;
(
  input  logic [DataW-1:0]    old_i,
  input  logic [DataW-1:0]    new_i,
  input  logic [NumLanes-1:0] be_i,
  output logic [DataW-1:0]    merged_o
);

  logic [DataW-1:0] mask;

  always_comb begin
    mask     = be_to_mask(be_i);
    merged_o = (old_i & ~mask) | (new_i & mask);
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Load/store responder for a word-write-only synchronous RAM; partial stores are
// completed by a read-modify-write through byte_merge.
module dmem_rmw_ctrl
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       addrb,
  input  logic [3:0]        web,
  input  logic [31:0]       dib,
  output logic [31:0]       DMEM_word,
  output logic              ack,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [NumLanes-1:0] AllLanes = '1;
  localparam logic [NumLanes-1:0] NoLanes  = '0;

  mem_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NumLanes-1:0] web_q, web_d;
  logic [DataW-1:0]    dib_q, dib_d;
  logic [DataW-1:0]    dmem_word_q, dmem_word_d;
  logic [DataW-1:0]    merged_word;
  logic [ADDR_W-1:0]   req_idx;
  logic                rd_bypass;

  // Byte offset and bits above the RAM depth are dropped so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{addrb[31:ADDR_W+2], addrb[1:0]};
  assign req_idx     = addrb[ADDR_W+1:2];

  byte_merge u_byte_merge (
    .old_i    (mem_rdata),
    .new_i    (dib_q),
    .be_i     (web_q),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    web_d       = web_q;
    dib_d       = dib_q;
    dmem_word_d = dmem_word_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = dib_q;
    ack         = 1'b0;
    stall       = 1'b0;
    rd_bypass   = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_addr  = req_idx;
        mem_wdata = dib;
        if (MemWrite || MemRead) begin
          addr_d = req_idx;
          web_d  = web;
          dib_d  = dib;
        end
        if (MemWrite) begin
          if (web == AllLanes) begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            ack    = 1'b1;
          end else if (web == NoLanes) begin
            ack = 1'b1;
          end else begin
            mem_en  = 1'b1;
            stall   = 1'b1;
            state_d = StRmwRd;
          end
        end else if (MemRead) begin
          mem_en  = 1'b1;
          stall   = 1'b1;
          state_d = StRdWait;
        end
      end

      StRmwRd: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged_word;
        ack       = 1'b1;
        state_d   = StIdle;
      end

      StRdWait: begin
        dmem_word_d = mem_rdata;
        rd_bypass   = 1'b1;
        ack         = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Reset silences the RAM port and handshake even mid-operation.
    if (!rst_n) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      ack       = 1'b0;
      stall     = 1'b0;
      rd_bypass = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      web_q       <= '0;
      dib_q       <= '0;
      dmem_word_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      web_q       <= web_d;
      dib_q       <= dib_d;
      dmem_word_q <= dmem_word_d;
    end
  end

  assign DMEM_word = rd_bypass ? mem_rdata : dmem_word_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: directed vector table, reset corner case, then random
// traffic against a word-array reference memory.
module tb_dmem_rmw_ctrl;

  localparam int unsigned AW    = 12;
  localparam int unsigned Words = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          MemWrite;
  logic          MemRead;
  logic [31:0]   addrb;
  logic [3:0]    web;
  logic [31:0]   dib;
  logic [31:0]   DMEM_word;
  logic          ack;
  logic          stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram     [Words];
  logic [31:0] ref_mem [Words];
  logic        init_en;
  logic [31:0] exp_dmem;
  int          tests;
  int          fails;

  dmem_rmw_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .addrb     (addrb),
    .web       (web),
    .dib       (dib),
    .DMEM_word (DMEM_word),
    .ack       (ack),
    .stall     (stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Synchronous RAM: one-cycle read latency, full-word write.
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < Words; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] res;
    for (int lane = 0; lane < 4; lane++) begin
      res[8*lane +: 8] = be[lane] ? new_w[8*lane +: 8] : old_w[8*lane +: 8];
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    addrb    = '0;
    web      = '0;
    dib      = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after ack.
  task automatic run_req(input logic w, input logic r, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input int lat, input logic [31:0] exp_word,
                         input string nm);
    logic [AW-1:0] idx;
    idx      = a[AW+1:2];
    MemWrite = w;
    MemRead  = r;
    addrb    = a;
    web      = be;
    dib      = d;
    #4;
    if (!w && !r) begin
      chk({nm, ".ack"}, ack, 0);
      chk({nm, ".stall"}, stall, 0);
      chk({nm, ".mem_en"}, mem_en, 0);
      chk({nm, ".dmem"}, DMEM_word, exp_dmem);
    end else if (lat == 0) begin
      chk({nm, ".ack"}, ack, 1);
      chk({nm, ".stall"}, stall, 0);
      chk({nm, ".dmem"}, DMEM_word, exp_dmem);
      if (be == 4'hF) begin
        chk({nm, ".mem_en"}, mem_en, 1);
        chk({nm, ".mem_we"}, mem_we, 1);
        chk({nm, ".mem_addr"}, {20'd0, mem_addr}, {20'd0, idx});
        chk({nm, ".mem_wdata"}, mem_wdata, exp_word);
      end else begin
        chk({nm, ".mem_en"}, mem_en, 0);
      end
    end else begin
      chk({nm, ".c0_ack"}, ack, 0);
      chk({nm, ".c0_stall"}, stall, 1);
      chk({nm, ".c0_mem_en"}, mem_en, 1);
      chk({nm, ".c0_mem_we"}, mem_we, 0);
      chk({nm, ".c0_mem_addr"}, {20'd0, mem_addr}, {20'd0, idx});
      chk({nm, ".c0_dmem"}, DMEM_word, exp_dmem);
      @(posedge clk);
      #5;
      chk({nm, ".c1_ack"}, ack, 1);
      chk({nm, ".c1_stall"}, stall, 0);
      if (w) begin
        chk({nm, ".c1_mem_we"}, mem_we, 1);
        chk({nm, ".c1_mem_addr"}, {20'd0, mem_addr}, {20'd0, idx});
        chk({nm, ".c1_mem_wdata"}, mem_wdata, exp_word);
        chk({nm, ".c1_dmem"}, DMEM_word, exp_dmem);
      end else begin
        chk({nm, ".c1_dmem"}, DMEM_word, exp_word);
        exp_dmem = exp_word;
      end
    end
    if (w) ref_mem[idx] = ref_merge(ref_mem[idx], d, be);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    int          lat;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rnd, a, d, exp_w;
    logic [11:0] idx;
    logic [3:0]  be;
    logic        w, r;
    int          op, lat;

    tests    = 0;
    fails    = 0;
    exp_dmem = '0;
    for (int i = 0; i < Words; i++) ref_mem[i] = init_val(i);

    vecs.push_back('{1, 0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, "sw_full"});
    vecs.push_back('{1, 0, 32'h0000_0010, 4'h4, 32'h00AA_0000, 1, 32'hDEAA_BEEF, "sb_lane2"});
    vecs.push_back('{0, 1, 32'h0000_0012, 4'h0, 32'h0, 1, 32'hDEAA_BEEF, "lw_after_sb"});
    vecs.push_back('{1, 0, 32'h0000_0010, 4'hF, 32'h1122_3344, 0, 32'h1122_3344, "sw_word4"});
    vecs.push_back('{0, 1, 32'h0000_0012, 4'h0, 32'h0, 1, 32'h1122_3344, "lw_word4"});
    vecs.push_back('{0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, "idle_hold"});
    vecs.push_back('{1, 0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, "sw_restore"});
    vecs.push_back('{1, 1, 32'h0000_0010, 4'h3, 32'h0000_CAFE, 1, 32'hDEAD_CAFE, "w_r_prio"});
    vecs.push_back('{0, 1, 32'h0000_0010, 4'h0, 32'h0, 1, 32'hDEAD_CAFE, "lw_after_prio"});
    vecs.push_back('{1, 0, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 0, 32'h0, "sw_empty"});
    vecs.push_back('{0, 1, 32'h0000_0010, 4'h0, 32'h0, 1, 32'hDEAD_CAFE, "lw_after_empty"});
    vecs.push_back('{1, 0, 32'hFFFF_C010, 4'hF, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, "sw_wrap"});
    vecs.push_back('{0, 1, 32'h0000_0013, 4'h0, 32'h0, 1, 32'h0BAD_F00D, "lw_wrap"});

    // Reset with a full-word store presented: no RAM activity may leak out.
    set_idle();
    rst_n    = 1'b0;
    init_en  = 1'b1;
    MemWrite = 1'b1;
    web      = 4'hF;
    addrb    = 32'h10;
    dib      = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    init_en = 1'b0;
    #3;
    chk("rst.mem_en", mem_en, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.ack", ack, 0);
    chk("rst.stall", stall, 0);
    @(posedge clk);
    #1;
    set_idle();
    rst_n = 1'b1;
    #4;
    chk("rst.dmem", DMEM_word, 32'h0);
    chk("rst.idle_ack", ack, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_req(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].be, vecs[i].d, vecs[i].lat, vecs[i].exp,
              vecs[i].nm);
    end

    // Reset asserted in the merge-write cycle abandons the partial store.
    MemWrite = 1'b1;
    addrb    = 32'h10;
    web      = 4'h1;
    dib      = 32'h0000_00FF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #4;
    chk("rmw_rst.mem_we", mem_we, 0);
    chk("rmw_rst.mem_en", mem_en, 0);
    chk("rmw_rst.ack", ack, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_idle();
    exp_dmem = '0;
    #4;
    chk("rmw_rst.dmem", DMEM_word, 32'h0);
    chk("rmw_rst.stall", stall, 0);
    @(posedge clk);
    #1;
    run_req(0, 1, 32'h10, 4'h0, 32'h0, 1, ref_mem[4], "rmw_rst.lw");

    // Random traffic on a small window of words, random high bits to exercise wrap.
    for (int n = 0; n < 300; n++) begin
      rnd = $urandom();
      idx = 12'($urandom_range(0, 15));
      a   = {rnd[31:14], idx, rnd[1:0]};
      d   = $urandom();
      be  = 4'($urandom_range(0, 15));
      op  = $urandom_range(0, 3);
      w   = (op == 1) || (op == 3);
      r   = (op == 2) || (op == 3);
      if (w) begin
        lat   = (be == 4'hF || be == 4'h0) ? 0 : 1;
        exp_w = ref_merge(ref_mem[idx], d, be);
      end else if (r) begin
        lat   = 1;
        exp_w = ref_mem[idx];
      end else begin
        lat   = 0;
        exp_w = '0;
      end
      run_req(w, r, a, be, d, lat, exp_w, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_ctrl.md
DMEM_RMW_CTRL -- requirements
Module: dmem_rmw_ctrl

Purpose: memory-side responder for load/store requests. Serves word and byte-enabled accesses against a word-only (single write-enable) synchronous data RAM. Partial stores use read-modify-write.

Interface
REQ-001 Parameter ADDR_W, 12, RAM word-address width (depth = 2**ADDR_W words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 MemWrite  input  1  store request.
REQ-005 MemRead  input  1  load request.
REQ-006 addrb  input  32  byte address; word index = addrb[ADDR_W+1:2]; higher bits ignored (wrap).
REQ-007 web  input  4  byte-lane write enables, lane i = dib[8i+7:8i].
REQ-008 dib  input  32  lane-aligned store data.
REQ-009 DMEM_word  output  32  full aligned word returned for loads; holds its value between loads.
REQ-010 ack  output  1  one-cycle pulse marking request completion.
REQ-011 stall  output  1  high while an accepted request is not yet complete.
REQ-012 mem_en  output  1  RAM port enable.
REQ-013 mem_we  output  1  RAM full-word write enable.
REQ-014 mem_addr  output  ADDR_W  RAM word address.
REQ-015 mem_wdata  output  32  RAM write data.
REQ-016 mem_rdata  input  32  RAM read data, valid one cycle after mem_en=1, mem_we=0.

Function
REQ-017 FSM states are IDLE, RD_WAIT and RMW_RD.
REQ-018 Requester holds MemWrite/MemRead/addrb/web/dib stable while stall=1; the block also latches addr/web/dib on acceptance and uses only the latched copies after IDLE.
REQ-019 MemWrite has priority over MemRead when both are high.
REQ-020 IDLE, MemWrite, web=4'b1111: mem_en=1, mem_we=1, mem_wdata=dib; ack=1 and stall=0 in the same cycle; stay IDLE (zero added latency).
REQ-021 IDLE, MemWrite, web=4'b0000: no RAM access; ack=1 same cycle; stay IDLE.
REQ-022 IDLE, MemWrite, web partial: issue RAM read (mem_en=1, mem_we=0); stall=1, ack=0; go to RMW_RD.
REQ-023 RMW_RD: mem_wdata = (mem_rdata AND ~mask) OR (dib_q AND mask), mask = each web_q bit replicated over 8 bits; mem_en=1, mem_we=1; ack=1, stall=0; go to IDLE.
REQ-024 IDLE, MemRead only: issue RAM read; stall=1; go to RD_WAIT.
REQ-025 RD_WAIT: DMEM_word register loads mem_rdata; ack=1, stall=0 this cycle; DMEM_word output shows mem_rdata combinationally this cycle and the registered value afterwards; go to IDLE.
REQ-026 Latency from acceptance: full-word or empty store 0 cycles; load and partial store 1 cycle; a new request is accepted in the cycle after ack.
REQ-027 A request presented outside IDLE is not accepted.
REQ-028 IDLE with no request: mem_en=0, ack=0, stall=0.
REQ-029 Back-to-back store then load to the same word returns the stored data (RAM write completes before the following read is issued).

Reset
REQ-030 While rst_n=0 at a clock edge: state to IDLE; DMEM_word, latched addr/web/dib cleared to 0.
REQ-031 While rst_n=0: mem_en=0, mem_we=0, ack=0, stall=0 regardless of state or inputs.
REQ-032 Reset during RMW_RD or RD_WAIT abandons the operation; no RAM write is issued and no ack is produced.

Structure
REQ-033 Shared package rv_mem_pkg holds the state encodings, the web-to-bitmask expansion function, and the word data width (32).
REQ-034 Byte-lane merge is one combinational sub-module, byte_merge (inputs old word, new word, 4-bit enable; output merged word).

Verification
REQ-035 SW: web=1111, addrb=0x10, dib=0xDEADBEEF -> same-cycle mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, ack=1, stall=0.
REQ-036 SB lane 2: word 4 = 0xDEADBEEF, web=0100, dib=0x00AA0000 -> cycle0 read with stall=1; cycle1 mem_wdata=0xDEAABEEF, ack=1; a following load returns 0xDEAABEEF.
REQ-037 LW: addrb=0x12, RAM word 4 = 0x11223344 -> cycle0 stall=1; cycle1 DMEM_word=0x11223344, ack=1; value held after.
REQ-038 MemWrite=MemRead=1, web=0011, dib=0x0000CAFE over 0xDEADBEEF -> store wins; written word 0xDEADCAFE; DMEM_word unchanged.
REQ-039 rst_n=0 asserted in RMW_RD cycle -> mem_we=0, ack=0, RAM word unchanged; after release state IDLE, DMEM_word=0.
REQ-040 MemWrite, web=0000 -> ack=1 same cycle, mem_en=0 throughout.
